// File: rtl/pixel_span_processor_pkg.sv
// Shared constants, descriptor payload and FSM state type for the span walker.
package pixel_span_processor_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned FX_BITS    = 16;
  localparam int unsigned COORD_BITS = 10;
  localparam int unsigned COLOR_BITS = 16;
  localparam int unsigned MAX_SPAN   = 64;

  localparam int unsigned LEN_BITS   = $clog2(MAX_SPAN) + 1;
  localparam int unsigned LEN_EXT    = LEN_BITS + 1;
  localparam int unsigned EDGE_BITS  = 2 * FX_BITS;
  localparam int unsigned Z_BITS     = 2 * FX_BITS;
  // Wide enough that a full span of steps never wraps an edge or depth accumulator.
  localparam int unsigned ACC_BITS   = EDGE_BITS + LEN_BITS + 1;
  localparam int unsigned LANE_SHIFT = $clog2(LANES);

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } span_state_e;

  // Per-span constants held for the duration of a walk.
  typedef struct packed {
    logic [COORD_BITS-1:0]       y;
    logic [LEN_BITS-1:0]         len;
    logic [2:0][EDGE_BITS-1:0]   dedx;
    logic [FX_BITS-1:0]          dzdx;
    logic [COLOR_BITS-1:0]       color;
    logic [2:0]                  tl_bias;
    logic                        skip_empty;
  } span_desc_t;

  function automatic logic [LEN_BITS-1:0] clamp_len(input logic [LEN_BITS-1:0] len);
    return (len > LEN_BITS'(MAX_SPAN)) ? LEN_BITS'(MAX_SPAN) : len;
  endfunction

endpackage

// File: rtl/span_lane_eval.sv
// One lane of a beat: edge-function coverage test and clamped depth.
//   e_acc/z_acc : accumulators at lane 0 of the beat
//   dedx/dzdx   : per-pixel steps (signed)
//   lane        : lane index within the beat
//   tl_bias     : per-edge top-left rule (set => zero counts as outside)
//   rem         : pixels remaining in the span from lane 0
//   covered_c   : lane pixel is inside the triangle and inside the span
//   z_c         : depth clamped to [0, 2^Z_BITS-1]
module span_lane_eval
  import pixel_span_processor_pkg::*;
(
  input  logic [2:0][ACC_BITS-1:0]  e_acc,
  input  logic [2:0][EDGE_BITS-1:0] dedx,
  input  logic [ACC_BITS-1:0]       z_acc,
  input  logic [FX_BITS-1:0]        dzdx,
  input  logic [LEN_BITS-1:0]       lane,
  input  logic [2:0]                tl_bias,
  input  logic [LEN_BITS-1:0]       rem,
  output logic                      covered_c,
  output logic [Z_BITS-1:0]         z_c
);

  logic signed [ACC_BITS-1:0] lane_s;
  logic signed [ACC_BITS-1:0] e_lane;
  logic signed [ACC_BITS-1:0] z_lane;
  logic                       e_neg;
  logic                       e_zero;

  // Coverage and depth for this lane's pixel position.
  always_comb begin
    lane_s    = $signed(ACC_BITS'(lane));
    covered_c = (lane < rem);
    e_lane    = '0;
    e_neg     = 1'b0;
    e_zero    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e_lane = $signed(e_acc[k]) + lane_s * $signed(ACC_BITS'($signed(dedx[k])));
      e_neg  = e_lane[ACC_BITS-1];
      e_zero = (e_lane == '0);
      if (e_neg || (e_zero && tl_bias[k])) begin
        covered_c = 1'b0;
      end
    end

    z_lane = $signed(z_acc) + lane_s * $signed(ACC_BITS'($signed(dzdx)));
    if (z_lane[ACC_BITS-1]) begin
      z_c = '0;
    end else if (z_lane[ACC_BITS-2:Z_BITS] != '0) begin
      z_c = '1;
    end else begin
      z_c = z_lane[Z_BITS-1:0];
    end
  end

endmodule

// File: rtl/pixel_span_processor.sv
// Walks one horizontal span descriptor LANES pixels per beat, producing a
// coverage mask, per-lane depth, colour and last flag per output beat.
//   vld_in/rdy_in   : descriptor handshake (rdy_in registered, high in IDLE)
//   in_*            : span descriptor fields
//   vld_out/rdy_out : beat handshake, single registered output stage
//   out_*           : beat payload, lane 0 in LSBs of out_mask/out_z
module pixel_span_processor
  import pixel_span_processor_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld_in,
  output logic                     rdy_in,
  input  logic [COORD_BITS-1:0]    in_x,
  input  logic [COORD_BITS-1:0]    in_y,
  input  logic [LEN_BITS-1:0]      in_len,
  input  logic [EDGE_BITS-1:0]     in_edge_0,
  input  logic [EDGE_BITS-1:0]     in_edge_1,
  input  logic [EDGE_BITS-1:0]     in_edge_2,
  input  logic [EDGE_BITS-1:0]     in_dedx_0,
  input  logic [EDGE_BITS-1:0]     in_dedx_1,
  input  logic [EDGE_BITS-1:0]     in_dedx_2,
  input  logic [Z_BITS-1:0]        in_z,
  input  logic [FX_BITS-1:0]       in_dzdx,
  input  logic [COLOR_BITS-1:0]    in_color,
  input  logic [2:0]               in_tl_bias,
  input  logic                     in_skip_empty,
  output logic                     vld_out,
  input  logic                     rdy_out,
  output logic [COORD_BITS-1:0]    out_x,
  output logic [COORD_BITS-1:0]    out_y,
  output logic [LANES-1:0]         out_mask,
  output logic [LANES*Z_BITS-1:0]  out_z,
  output logic [COLOR_BITS-1:0]    out_color,
  output logic                     out_last
);

  span_state_e               state_q;
  span_state_e               state_d;
  span_desc_t                desc_q;
  logic [2:0][ACC_BITS-1:0]  e_q;
  logic [ACC_BITS-1:0]       z_q;
  logic [COORD_BITS-1:0]     x_q;
  logic [LEN_BITS-1:0]       off_q;

  logic                      accept_c;
  logic                      adv_c;
  logic                      last_c;
  logic                      drop_c;
  logic [LEN_BITS-1:0]       rem_c;
  logic [LANES-1:0]          mask_c;
  logic [LANES*Z_BITS-1:0]   z_lanes_c;

  // Beat bookkeeping; off never exceeds len while walking.
  assign rem_c  = desc_q.len - off_q;
  assign last_c = (LEN_EXT'(off_q) + LEN_EXT'(LANES)) >= LEN_EXT'(desc_q.len);
  assign drop_c = desc_q.skip_empty && !last_c && (mask_c == '0);

  // Per-lane coverage and depth for the beat at the current offset.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    span_lane_eval u_lane (
      .e_acc     (e_q),
      .dedx      (desc_q.dedx),
      .z_acc     (z_q),
      .dzdx      (desc_q.dzdx),
      .lane      (LEN_BITS'(i)),
      .tl_bias   (desc_q.tl_bias),
      .rem       (rem_c),
      .covered_c (mask_c[i]),
      .z_c       (z_lanes_c[i*Z_BITS +: Z_BITS])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus accept/advance strobes.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    adv_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vld_in && rdy_in) begin
          accept_c = 1'b1;
          state_d  = WALK;
        end
      end
      WALK: begin
        // A beat is produced (or dropped) only when the output register is free.
        if (!vld_out || rdy_out) begin
          adv_c = 1'b1;
          if (last_c) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Descriptor latch, walk accumulators and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_in    <= 1'b0;
      desc_q    <= '0;
      e_q       <= '0;
      z_q       <= '0;
      x_q       <= '0;
      off_q     <= '0;
      vld_out   <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_mask  <= '0;
      out_z     <= '0;
      out_color <= '0;
      out_last  <= 1'b0;
    end else begin
      rdy_in <= (state_d == IDLE);

      if (accept_c) begin
        desc_q.y          <= in_y;
        desc_q.len        <= clamp_len(in_len);
        desc_q.dedx       <= {in_dedx_2, in_dedx_1, in_dedx_0};
        desc_q.dzdx       <= in_dzdx;
        desc_q.color      <= in_color;
        desc_q.tl_bias    <= in_tl_bias;
        desc_q.skip_empty <= in_skip_empty;
        e_q[0]            <= ACC_BITS'($signed(in_edge_0));
        e_q[1]            <= ACC_BITS'($signed(in_edge_1));
        e_q[2]            <= ACC_BITS'($signed(in_edge_2));
        z_q               <= ACC_BITS'(in_z);
        x_q               <= in_x;
        off_q             <= '0;
      end

      if (adv_c) begin
        for (int k = 0; k < 3; k++) begin
          e_q[k] <= e_q[k] + (ACC_BITS'($signed(desc_q.dedx[k])) << LANE_SHIFT);
        end
        z_q   <= z_q + (ACC_BITS'($signed(desc_q.dzdx)) << LANE_SHIFT);
        x_q   <= x_q + COORD_BITS'(LANES);
        off_q <= off_q + LEN_BITS'(LANES);

        if (!drop_c) begin
          vld_out   <= 1'b1;
          out_x     <= x_q;
          out_y     <= desc_q.y;
          out_mask  <= mask_c;
          out_z     <= z_lanes_c;
          out_color <= desc_q.color;
          out_last  <= last_c;
        end else begin
          vld_out <= 1'b0;
        end
      end else if (rdy_out) begin
        vld_out <= 1'b0;
      end
    end
  end

endmodule
